// File: rtl/vec_load_gather_if.sv
// vec_load_gather_if: load request, memory read and vector write bundle.
// slave = gather unit, master = decode stage + memory + register bank.
interface vec_load_gather_if #(
  parameter int LANES = 4
);
  logic                  start;
  logic [31:0]           base_addr;
  logic [31:0]           stride;
  logic [3:0]            dst;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_re;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;
  logic                  vwe;
  logic [3:0]            vwa;
  logic [LANES*32-1:0]   vwd;

  modport slave (
    input  start, base_addr, stride, dst,
    input  mem_rdata, mem_rvalid,
    output busy, done, err,
    output mem_re, mem_addr,
    output vwe, vwa, vwd
  );

  modport master (
    output start, base_addr, stride, dst,
    output mem_rdata, mem_rvalid,
    input  busy, done, err,
    input  mem_re, mem_addr,
    input  vwe, vwa, vwd
  );
endinterface

// File: rtl/vec_load_gather.sv
// vec_load_gather: reads LANES words at base+k*stride, one read in flight,
// then writes them to the vector bank in one cycle.
// Ports: clk, rst (async, active-low), bus (slave modport):
//   start/base_addr/stride/dst  load request, taken only when idle
//   busy/done/err               status; done pulses with vwe, err on abort
//   mem_re/mem_addr             read request pulse, address held meanwhile
//   mem_rdata/mem_rvalid        read response
//   vwe/vwa/vwd                 vector write port, lane k at [32k+31:32k]
module vec_load_gather #(
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  vec_load_gather_if.slave bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE
  } state_t;

  state_t        state;
  logic [31:0]   addr;
  logic [31:0]   stride_q;
  logic [3:0]    dst_q;
  logic [LW-1:0] lane;
  logic [TW-1:0] tcnt;
  logic [31:0]   rbuf [LANES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr         <= '0;
      stride_q     <= '0;
      dst_q        <= '0;
      lane         <= '0;
      tcnt         <= '0;
      for (int k = 0; k < LANES; k++)
        rbuf[k] <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.mem_re   <= 1'b0;
      bus.mem_addr <= '0;
      bus.vwe      <= 1'b0;
      bus.vwa      <= '0;
      bus.vwd      <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.mem_re <= 1'b0;
      bus.vwe    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            stride_q     <= bus.stride;
            dst_q        <= bus.dst;
            addr         <= bus.base_addr;
            lane         <= '0;
            bus.mem_re   <= 1'b1;
            bus.mem_addr <= bus.base_addr;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // rvalid during the request cycle is not a response
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            rbuf[lane] <= bus.mem_rdata;
            if (lane == LAST) begin
              // last lane bypasses the buffer straight into vwd
              for (int k = 0; k < LANES; k++)
                bus.vwd[k*32 +: 32] <= (k == LANES - 1) ?
                  bus.mem_rdata : rbuf[k];
              bus.vwa  <= dst_q;
              bus.vwe  <= 1'b1;
              bus.done <= 1'b1;
              state    <= WRITE;
            end else begin
              lane         <= lane + 1'b1;
              addr         <= addr + stride_q;
              bus.mem_re   <= 1'b1;
              bus.mem_addr <= addr + stride_q;
              state        <= ISSUE;
            end
          end else if (tcnt == TLIM) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WRITE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_load_gather.sv
// tb_vec_load_gather: directed checks of vec_load_gather
// with a small responder standing in for data memory.
module tb_vec_load_gather;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_load_gather_if #(.LANES(4)) bus ();

  vec_load_gather #(
    .LANES(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]  mdata [4];
  int           mdly  [4];
  logic [31:0]  ra    [8];
  int           nre, nvwe, nerr, vcyc, ecyc;
  int           hold_bad, pair_bad, inj_cyc, rst_cyc;
  int           x_re, x_vwe;
  logic [127:0] vwd_q;
  logic [3:0]   vwa_q;
  logic         busy_after, vwe_after, ended;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called on a negedge; returns after the load ends
  task automatic run_load(input logic [31:0] b,
                          input logic [31:0] s,
                          input logic [3:0]  d);
    int pl, wc;
    nre = 0; nvwe = 0; nerr = 0; vcyc = -1; ecyc = -1;
    hold_bad = 0; pair_bad = 0; ended = 1'b0;
    busy_after = 1'b1; vwe_after = 1'b1;
    pl = -1; wc = 0;
    bus.start = 1'b1; bus.base_addr = b;
    bus.stride = s;   bus.dst = d;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (cyc == inj_cyc) begin
        bus.start = 1'b1; bus.dst = 4'd7;
        bus.base_addr = 32'h999;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b0; ended = 1'b1;
        break;
      end
      if (vcyc >= 0 || ecyc >= 0) begin
        busy_after = bus.busy; vwe_after = bus.vwe;
        ended = 1'b1;
        break;
      end
      if (bus.mem_re) begin
        if (nre < 8) ra[nre] = bus.mem_addr;
        pl = (nre < 4) ? nre : -1;
        wc = 0; nre++;
      end else if (pl >= 0) begin
        if (bus.mem_addr !== ra[pl]) hold_bad++;
        if (mdly[pl] >= 0 && wc == mdly[pl]) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mdata[pl];
          pl = -1;
        end else begin
          wc++;
        end
      end
      if (bus.done !== bus.vwe || (bus.err && bus.vwe)) pair_bad++;
      if (bus.vwe) begin
        nvwe++; vcyc = cyc;
        vwd_q = bus.vwd; vwa_q = bus.vwa;
      end
      if (bus.err) begin
        nerr++; ecyc = cyc;
      end
    end
    bus.start = 1'b0; bus.mem_rvalid = 1'b0;
    chk("load_terminated", ended, 1'b1);
  endtask

  task automatic idle(input int n);
    x_re = 0; x_vwe = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.mem_re) x_re++;
      if (bus.vwe)    x_vwe++;
    end
  endtask

  task automatic set_mem(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      mdata[k] = base + 32'(k);
      mdly[k]  = 0;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0;
    bus.stride = '0;  bus.dst = '0;
    bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
    inj_cyc = -1; rst_cyc = -1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_memre", bus.mem_re, 1'b0);
    chk("rst_vwe", bus.vwe, 1'b0);
    chk("rst_vwd", bus.vwd, 128'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1: unit stride, zero-wait memory
    set_mem(32'hA0);
    run_load(32'h100, 32'd4, 4'd2);
    chk("t1_nre", nre, 4);
    chk("t1_a0", ra[0], 32'h100);
    chk("t1_a1", ra[1], 32'h104);
    chk("t1_a2", ra[2], 32'h108);
    chk("t1_a3", ra[3], 32'h10C);
    chk("t1_vwe_cyc", vcyc, 9);
    chk("t1_nvwe", nvwe, 1);
    chk("t1_vwa", vwa_q, 4'd2);
    chk("t1_vwd", vwd_q,
        128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_done_pair", pair_bad, 0);
    chk("t1_nerr", nerr, 0);
    chk("t1_busy_after", busy_after, 1'b0);
    chk("t1_vwe_pulse", vwe_after, 1'b0);
    idle(2);

    // 2a: negative stride
    set_mem(32'h11);
    run_load(32'h20, 32'hFFFF_FFF8, 4'd3);
    chk("t2a_a0", ra[0], 32'h20);
    chk("t2a_a1", ra[1], 32'h18);
    chk("t2a_a2", ra[2], 32'h10);
    chk("t2a_a3", ra[3], 32'h08);
    chk("t2a_vwd", vwd_q,
        128'h00000014_00000013_00000012_00000011);
    idle(2);

    // 2b: address wrap
    run_load(32'hFFFF_FFF8, 32'd4, 4'd4);
    chk("t2b_a0", ra[0], 32'hFFFF_FFF8);
    chk("t2b_a1", ra[1], 32'hFFFF_FFFC);
    chk("t2b_a2", ra[2], 32'h0);
    chk("t2b_a3", ra[3], 32'h4);
    chk("t2b_vwa", vwa_q, 4'd4);
    idle(2);

    // 3: lane 1 answers 3 cycles late
    set_mem(32'hB0);
    mdly[1] = 3;
    run_load(32'h200, 32'd16, 4'd1);
    chk("t3_hold", hold_bad, 0);
    chk("t3_vwe_cyc", vcyc, 12);
    chk("t3_nvwe", nvwe, 1);
    chk("t3_lane1", vwd_q[63:32], 32'hB1);
    chk("t3_vwd", vwd_q,
        128'h000000B3_000000B2_000000B1_000000B0);
    idle(2);

    // 4: lane 2 never answers
    set_mem(32'hC0);
    mdly[2] = -1;
    run_load(32'h300, 32'd4, 4'd6);
    chk("t4_err_cyc", ecyc, 22);
    chk("t4_nerr", nerr, 1);
    chk("t4_nvwe", nvwe, 0);
    chk("t4_nre", nre, 3);
    chk("t4_busy_after", busy_after, 1'b0);
    idle(2);
    chk("t4_idle_vwe", x_vwe, 0);
    set_mem(32'hD0);
    run_load(32'h400, 32'd4, 4'd6);
    chk("t4_next_vwd", vwd_q,
        128'h000000D3_000000D2_000000D1_000000D0);
    chk("t4_next_nerr", nerr, 0);
    idle(2);

    // 5: start during WAIT is dropped
    set_mem(32'hE0);
    inj_cyc = 4;
    run_load(32'h500, 32'd4, 4'd5);
    chk("t5_vwa", vwa_q, 4'd5);
    chk("t5_nre", nre, 4);
    chk("t5_nvwe", nvwe, 1);
    idle(4);
    chk("t5_no_reload", x_re, 0);

    // 5b: start during the WRITE cycle is dropped
    inj_cyc = 9;
    run_load(32'h600, 32'd4, 4'd8);
    chk("t5b_vwa", vwa_q, 4'd8);
    idle(4);
    chk("t5b_no_reload", x_re, 0);
    inj_cyc = -1;

    // 6: async reset in lane 3 WAIT
    set_mem(32'hF0);
    mdly[3] = -1;
    rst_cyc = 9;
    run_load(32'h700, 32'd4, 4'd9);
    #1;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_maddr", bus.mem_addr, 32'h0);
    chk("t6_vwa", bus.vwa, 4'd0);
    chk("t6_vwd", bus.vwd, 128'h0);
    chk("t6_nvwe", nvwe, 0);
    idle(2);
    chk("t6_idle_vwe", x_vwe, 0);
    rst = 1'b1;
    rst_cyc = -1;
    @(negedge clk);
    set_mem(32'h50);
    run_load(32'h800, 32'd4, 4'd10);
    chk("t6_post_vwa", vwa_q, 4'd10);
    chk("t6_post_vwd", vwd_q,
        128'h00000053_00000052_00000051_00000050);
    chk("t6_post_cyc", vcyc, 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
